// File: rtl/dcache.sv
// dcache: direct-mapped write-back, write-allocate data cache with 8-word lines.
// Optional DCACHE_PERF_CNT_EN adds saturating hit_count/miss_count outputs.
module dcache #(
  parameter int SETS_LOG2 = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic [127:0] pmem_rdata,
  output logic [127:0] pmem_wdata,
`ifdef DCACHE_PERF_CNT_EN
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count,
`endif
  input  logic         pmem_resp
);
  localparam int SETS = 1 << SETS_LOG2;
  localparam int TW = 12 - SETS_LOG2;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t state, next;
  logic [127:0] data [SETS];
  logic [TW-1:0] tags [SETS];
  logic [SETS-1:0] valid, dirty;
  logic [SETS_LOG2-1:0] idx, miss_idx;
  logic [TW-1:0] tag, miss_tag;
  logic [2:0] word;
  logic hit, req, wr_hit, fill_done, addr_unused;
  assign idx = mem_address[3+SETS_LOG2:4];
  assign tag = mem_address[15:4+SETS_LOG2];
  assign word = mem_address[3:1];
  assign addr_unused = mem_address[0];
  assign req = mem_read | mem_write;
  assign hit = valid[idx] && tags[idx] == tag;
  assign wr_hit = state == IDLE && mem_write && hit;
  assign fill_done = state == FILL && pmem_resp;
  assign mem_rdata = mem_resp ? data[idx][{word, 4'h0} +: 16] : 16'h0000;
  always_comb begin
    next = state;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = {miss_tag, miss_idx, 4'b0};
    pmem_wdata = data[miss_idx];
    case (state)
      IDLE: begin
        mem_resp = req && hit;
        if (req && !hit) next = valid[idx] && dirty[idx] ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_address = {tags[miss_idx], miss_idx, 4'b0};
        if (pmem_resp) next = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= next;
      if (wr_hit) dirty[idx] <= 1'b1;
      if (fill_done) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
      end
    end
  // Miss address is captured so the sequence survives the CPU dropping or changing its request.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      miss_idx <= idx;
      miss_tag <= tag;
    end
    if (wr_hit && mem_byte_enable[0]) data[idx][{word, 4'h0} +: 8] <= mem_wdata[7:0];
    if (wr_hit && mem_byte_enable[1]) data[idx][{word, 4'h8} +: 8] <= mem_wdata[15:8];
    if (fill_done) begin
      data[miss_idx] <= pmem_rdata;
      tags[miss_idx] <= miss_tag;
    end
  end
`ifdef DCACHE_PERF_CNT_EN
  logic after_fill;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hit_count <= '0;
      miss_count <= '0;
      after_fill <= 1'b0;
    end else begin
      after_fill <= fill_done;
      if (mem_resp && !after_fill && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (state == IDLE && next != IDLE && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
`endif
endmodule
